// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter feeding one shared 15->32 bit immediate extender with a registered valid/ready output.
// Optional macro IMM_EXT_ARBITER_LUI_EN enables upper placement for mode 11 (otherwise mode 11 zero-extends).
module imm_ext_arbiter #(
  parameter int IMM_W  = 15,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [IMM_W-1:0]  req0_imm,
  input  logic [1:0]        req0_mode,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [IMM_W-1:0]  req1_imm,
  input  logic [1:0]        req1_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_q, state_d;
  logic               rr_q;
  logic [DATA_W-1:0]  data_q;
  logic               src_q;

  logic               can_accept;
  logic               grant0, grant1;
  logic               accept;
  logic [IMM_W-1:0]   sel_imm;
  logic [1:0]         sel_mode;
  logic [DATA_W-1:0]  zext, sext, ext;

  // rr_q names the requester that wins when both are valid
  assign grant0 = req0_valid & (~req1_valid | ~rr_q);
  assign grant1 = req1_valid & (~req0_valid |  rr_q);

  assign can_accept = (state_q == EMPTY) | out_ready;
  assign accept     = can_accept & (req0_valid | req1_valid) & rst_n;
  assign req0_ready = can_accept & grant0 & rst_n;
  assign req1_ready = can_accept & grant1 & rst_n;

  assign sel_imm  = grant1 ? req1_imm  : req0_imm;
  assign sel_mode = grant1 ? req1_mode : req0_mode;
  assign zext     = {{(DATA_W-IMM_W){1'b0}}, sel_imm};
  assign sext     = {{(DATA_W-IMM_W){sel_imm[IMM_W-1]}}, sel_imm};

  always_comb begin
    ext = zext;
    case (sel_mode)
      2'b00: ext = zext;
      2'b01: ext = sext;
      2'b10: ext = {sext[DATA_W-3:0], 2'b00};
`ifdef IMM_EXT_ARBITER_LUI_EN
      2'b11: ext = {sel_imm, {(DATA_W-IMM_W){1'b0}}};
`else
      2'b11: ext = zext;
`endif
      default: ext = zext;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rr_q    <= 1'b0;
      data_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= ext;
        src_q  <= grant1;
        rr_q   <= ~grant1;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed testbench for imm_ext_arbiter: reset, extension modes, round-robin, backpressure, mid-op reset.
module tb_imm_ext_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [14:0] req0_imm;
  logic [1:0]  req0_mode;
  logic        req1_valid, req1_ready;
  logic [14:0] req1_imm;
  logic [1:0]  req1_mode;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_src;

  int tests;
  int fails;

  imm_ext_arbiter #(.IMM_W(15), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_imm(req0_imm), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_imm(req1_imm), .req1_mode(req1_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b1; req0_imm = 15'h1234; req0_mode = 2'b01; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL reset_ready0 cyc%0d got %b exp 0", i, req0_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid cyc%0d got %b exp 0", i, out_valid); end
      tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_data cyc%0d got %h exp 0", i, out_data); end
    end
    req0_valid = 1'b0;
    rst_n = 1'b1;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_release_valid got %b exp 0", out_valid); end
    $display("[TB] reset: done");
  endtask

  task automatic test_sign_ext();
    req0_valid = 1'b1; req0_imm = 15'h4000; req0_mode = 2'b01; out_ready = 1'b1;
    #1;
    tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL sext_ready got %b exp 1", req0_ready); end
    step();
    req0_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sext_valid got %b exp 1", out_valid); end
    tests++; if (out_data !== 32'hFFFF_C000) begin fails++; $display("FAIL sext_data got %h exp FFFFC000", out_data); end
    tests++; if (out_src !== 1'b0) begin fails++; $display("FAIL sext_src got %b exp 0", out_src); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sext_drain got %b exp 0", out_valid); end
    $display("[TB] sign-ext: imm=4000 -> %h", 32'hFFFF_C000);
  endtask

  task automatic test_zero_ext();
    req0_valid = 1'b1; req0_imm = 15'h4000; req0_mode = 2'b00;
    step();
    req0_valid = 1'b0;
    tests++; if (out_data !== 32'h0000_4000) begin fails++; $display("FAIL zext_data got %h exp 00004000", out_data); end
    step();
    $display("[TB] zero-ext: imm=4000 -> 00004000");
  endtask

  task automatic test_branch();
    req1_valid = 1'b1; req1_imm = 15'h7FFF; req1_mode = 2'b10;
    #1;
    tests++; if (req1_ready !== 1'b1) begin fails++; $display("FAIL br_ready got %b exp 1", req1_ready); end
    step();
    tests++; if (out_data !== 32'hFFFF_FFFC) begin fails++; $display("FAIL br_neg_data got %h exp FFFFFFFC", out_data); end
    tests++; if (out_src !== 1'b1) begin fails++; $display("FAIL br_neg_src got %b exp 1", out_src); end
    req1_imm = 15'h3FFF;
    step();
    req1_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL br_pos_valid got %b exp 1", out_valid); end
    tests++; if (out_data !== 32'h0000_FFFC) begin fails++; $display("FAIL br_pos_data got %h exp 0000FFFC", out_data); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL br_drain got %b exp 0", out_valid); end
    $display("[TB] branch: 7FFF->FFFFFFFC 3FFF->0000FFFC");
  endtask

  task automatic test_fairness();
    logic        exp_src;
    logic [31:0] exp_data;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_imm = 15'h0011; req0_mode = 2'b00;
    req1_valid = 1'b1; req1_imm = 15'h0022; req1_mode = 2'b00;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_src  = i[0];
      exp_data = exp_src ? 32'h22 : 32'h11;
      #1;
      tests++; if (req0_ready !== ~exp_src || req1_ready !== exp_src) begin
        fails++; $display("FAIL rr_ready cyc%0d got %b%b exp %b%b", i, req1_ready, req0_ready, exp_src, ~exp_src);
      end
      step();
      tests++; if (out_valid !== 1'b1 || out_src !== exp_src || out_data !== exp_data) begin
        fails++; $display("FAIL rr_out cyc%0d got v=%b src=%b d=%h exp v=1 src=%b d=%h", i, out_valid, out_src, out_data, exp_src, exp_data);
      end
      $display("[TB] fairness cyc%0d: src=%b data=%h", i, out_src, out_data);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req0_imm = 15'h0100 + 15'(i);
      req1_imm = 15'h0200 + 15'(i);
      #1;
      tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        fails++; $display("FAIL bp_ready cyc%0d got %b%b exp 00", i, req1_ready, req0_ready);
      end
      step();
      tests++; if (out_valid !== 1'b1 || out_src !== 1'b1 || out_data !== 32'h22) begin
        fails++; $display("FAIL bp_hold cyc%0d got v=%b src=%b d=%h exp v=1 src=1 d=00000022", i, out_valid, out_src, out_data);
      end
    end
    req0_imm = 15'h0055;
    out_ready = 1'b1;
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL bp_release_ready got %b%b exp 01", req1_ready, req0_ready);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 32'h55) begin
      fails++; $display("FAIL bp_passthru got v=%b src=%b d=%h exp v=1 src=0 d=00000055", out_valid, out_src, out_data);
    end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b exp 0", out_valid); end
    $display("[TB] backpressure: held 5 cycles, released with pass-through");
  endtask

  task automatic test_lui_mode();
    logic [31:0] exp_data;
`ifdef IMM_EXT_ARBITER_LUI_EN
    exp_data = 32'h0002_0000;
`else
    exp_data = 32'h0000_0001;
`endif
    req0_valid = 1'b1; req0_imm = 15'h0001; req0_mode = 2'b11;
    step();
    req0_valid = 1'b0;
    tests++; if (out_data !== exp_data) begin fails++; $display("FAIL mode11_data got %h exp %h", out_data, exp_data); end
    step();
    $display("[TB] mode11: imm=0001 -> %h", exp_data);
  endtask

  task automatic test_reset_midop();
    req1_valid = 1'b1; req1_imm = 15'h0077; req1_mode = 2'b00; out_ready = 1'b0;
    step();
    req1_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midrst_fill got %b exp 1", out_valid); end
    rst_n = 1'b0; req0_valid = 1'b1; out_ready = 1'b1;
    #1;
    tests++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready got %b exp 0", req0_ready); end
    step();
    tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 1'b0) begin
      fails++; $display("FAIL midrst_clear got v=%b src=%b d=%h exp 0 0 0", out_valid, out_src, out_data);
    end
    req0_valid = 1'b0; rst_n = 1'b1;
    step();
    $display("[TB] reset mid-op: pending result discarded");
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b0; req0_imm = '0; req0_mode = '0;
    req1_valid = 1'b0; req1_imm = '0; req1_mode = '0;
    test_reset();
    test_sign_ext();
    test_zero_ext();
    test_branch();
    test_fairness();
    test_backpressure();
    test_lui_mode();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
